// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit.
//   MDUOp codes, FSM state encoding and the default op latencies. The hazard
//   unit decodes "is MD instruction" from these same codes.
package mdu_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned CNT_W  = 4;

    localparam logic [OP_W-1:0] OP_NONE  = 4'd0;
    localparam logic [OP_W-1:0] OP_MULT  = 4'd1;
    localparam logic [OP_W-1:0] OP_MULTU = 4'd2;
    localparam logic [OP_W-1:0] OP_DIV   = 4'd3;
    localparam logic [OP_W-1:0] OP_DIVU  = 4'd4;
    localparam logic [OP_W-1:0] OP_MTHI  = 4'd5;
    localparam logic [OP_W-1:0] OP_MTLO  = 4'd6;
    localparam logic [OP_W-1:0] OP_MFHI  = 4'd7;
    localparam logic [OP_W-1:0] OP_MFLO  = 4'd8;

    localparam int unsigned DEF_MULT_CYCLES = 5;
    localparam int unsigned DEF_DIV_CYCLES  = 10;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Multi-cycle arithmetic ops (the ones that raise Busy).
    function automatic logic is_arith_op(input logic [OP_W-1:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_div_op(input logic [OP_W-1:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mdu.sv
// mdu: multi-cycle multiply/divide unit holding the architectural HI/LO.
//   clk    : clock, all state on posedge
//   reset  : synchronous active-low reset
//   Start  : one-cycle issue pulse for MDUOp
//   MDUOp  : operation code (MFHI/MFLO select Result regardless of Start)
//   A, B   : rs / rt operands (A is also the mthi/mtlo data)
//   Busy   : a mult/div is in flight (registered state decode)
//   HI, LO : committed HI/LO registers
//   Result : combinational HI/LO read for mfhi/mflo, else 0
module mdu
    import mdu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int unsigned DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                Start,
    input  logic [OP_W-1:0]     MDUOp,
    input  logic [DATA_W-1:0]   A,
    input  logic [DATA_W-1:0]   B,
    output logic                Busy,
    output logic [DATA_W-1:0]   HI,
    output logic [DATA_W-1:0]   LO,
    output logic [DATA_W-1:0]   Result
);

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_hi;
    logic [DATA_W-1:0]   r_lo;
    logic [DATA_W-1:0]   r_temp_hi;
    logic [DATA_W-1:0]   r_temp_lo;
    logic                r_skip;

    logic [2*DATA_W-1:0] w_prod_s;
    logic [2*DATA_W-1:0] w_prod_u;
    logic [DATA_W-1:0]   w_a_mag;
    logic [DATA_W-1:0]   w_b_mag;
    logic [DATA_W-1:0]   w_bu;
    logic [DATA_W-1:0]   w_sq_mag;
    logic [DATA_W-1:0]   w_sr_mag;
    logic [DATA_W-1:0]   w_sq;
    logic [DATA_W-1:0]   w_sr;
    logic [2*DATA_W-1:0] w_temp;
    logic                w_div0;
    logic [CNT_W-1:0]    w_lat;

    // 64-bit result of the arithmetic op; signed division via magnitudes so the
    // 0x80000000 / -1 case wraps to 0x80000000 without a special case.
    always_comb begin
        w_prod_s = {{DATA_W{A[DATA_W-1]}}, A} * {{DATA_W{B[DATA_W-1]}}, B};
        w_prod_u = {{DATA_W{1'b0}}, A} * {{DATA_W{1'b0}}, B};
        w_div0   = (B == '0);
        w_a_mag  = A[DATA_W-1] ? (~A + 32'd1) : A;
        // Divisor forced to 1 on divide-by-zero; the result is discarded anyway.
        w_b_mag  = w_div0 ? 32'd1 : (B[DATA_W-1] ? (~B + 32'd1) : B);
        w_bu     = w_div0 ? 32'd1 : B;
        w_sq_mag = w_a_mag / w_b_mag;
        w_sr_mag = w_a_mag % w_b_mag;
        w_sq     = (A[DATA_W-1] ^ B[DATA_W-1]) ? (~w_sq_mag + 32'd1) : w_sq_mag;
        w_sr     = A[DATA_W-1] ? (~w_sr_mag + 32'd1) : w_sr_mag;
        w_temp   = '0;
        case (MDUOp)
            OP_MULT:  w_temp = w_prod_s;
            OP_MULTU: w_temp = w_prod_u;
            OP_DIV:   w_temp = {w_sr, w_sq};
            OP_DIVU:  w_temp = {A % w_bu, A / w_bu};
            default:  w_temp = '0;
        endcase
        w_lat = is_div_op(MDUOp) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end

    // Control FSM plus HI/LO/temp registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_temp_hi <= '0;
            r_temp_lo <= '0;
            r_skip    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (Start) begin
                        if (is_arith_op(MDUOp)) begin
                            r_temp_hi <= w_temp[2*DATA_W-1:DATA_W];
                            r_temp_lo <= w_temp[DATA_W-1:0];
                            r_skip    <= is_div_op(MDUOp) && w_div0;
                            r_cnt     <= w_lat;
                            r_state   <= RUN;
                        end else if (MDUOp == OP_MTHI) begin
                            r_hi <= A;
                        end else if (MDUOp == OP_MTLO) begin
                            r_lo <= A;
                        end
                    end
                end
                RUN: begin
                    // Start is ignored here; commit on the edge the count hits 0.
                    if (r_cnt <= CNT_W'(1)) begin
                        r_cnt   <= '0;
                        r_state <= IDLE;
                        if (!r_skip) begin
                            r_hi <= r_temp_hi;
                            r_lo <= r_temp_lo;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign Busy = (r_state == RUN);
    assign HI   = r_hi;
    assign LO   = r_lo;

    // mfhi/mflo read path, committed values only.
    always_comb begin
        Result = '0;
        case (MDUOp)
            OP_MFHI: Result = r_hi;
            OP_MFLO: Result = r_lo;
            default: Result = '0;
        endcase
    end

endmodule

// File: tb/tb_mdu.sv
// tb_mdu: scoreboard bench for mdu with a behavioural HI/LO reference model.
module tb_mdu;

    localparam int unsigned MULT_LAT = 5;
    localparam int unsigned DIV_LAT  = 10;

    logic        clk;
    logic        reset;
    logic        Start;
    logic [3:0]  MDUOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] Result;

    mdu #(.MULT_CYCLES(MULT_LAT), .DIV_CYCLES(DIV_LAT)) dut (
        .clk(clk), .reset(reset), .Start(Start), .MDUOp(MDUOp), .A(A), .B(B),
        .Busy(Busy), .HI(HI), .LO(LO), .Result(Result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          len;
        string       name;
    } exp_t;

    exp_t        sb_q[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] m_hi = 0;
    logic [31:0] m_lo = 0;

    int   mon_len  = 0;
    logic mon_prev = 1'b0;

    task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Reference: architectural result of an arithmetic op from plain integer maths.
    task automatic model_arith(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                               output logic [31:0] hi, output logic [31:0] lo, output int len);
        int               sa, sb;
        longint           p, q, r;
        longint unsigned  up;
        sa = a; sb = b;
        hi = m_hi; lo = m_lo;
        len = (op == 4'd3 || op == 4'd4) ? DIV_LAT : MULT_LAT;
        case (op)
            4'd1: begin p = longint'(sa) * longint'(sb); hi = p[63:32]; lo = p[31:0]; end
            4'd2: begin up = {32'd0, a} * {32'd0, b}; hi = up[63:32]; lo = up[31:0]; end
            4'd3: if (b != 0) begin
                q = longint'(sa) / longint'(sb); r = longint'(sa) % longint'(sb);
                hi = r[31:0]; lo = q[31:0];
            end
            4'd4: if (b != 0) begin hi = a % b; lo = a / b; end
            default: ;
        endcase
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        Start = 1'b1; MDUOp = op; A = a; B = b;
        @(posedge clk);
        #1;
        Start = 1'b0; MDUOp = 4'd0;
    endtask

    // Issue an arithmetic op: push expectation, update model, drive.
    task automatic issue_arith(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                               input string nm);
        exp_t e;
        model_arith(op, a, b, e.hi, e.lo, e.len);
        e.name = nm;
        sb_q.push_back(e);
        m_hi = e.hi; m_lo = e.lo;
        drive(op, a, b);
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (Busy && n < 40) begin @(negedge clk); n++; end
        if (Busy) begin
            errors++; checks++;
            $display("FAIL wait_idle: Busy still 1 after %0d cycles, expected 0", n);
        end
    endtask

    task automatic mt(input logic [3:0] op, input logic [31:0] a);
        drive(op, a, 32'd0);
        if (op == 4'd5) m_hi = a; else m_lo = a;
        @(negedge clk);
        check32(op == 4'd5 ? "mthi_HI" : "mtlo_LO", op == 4'd5 ? HI : LO, a);
    endtask

    task automatic read_result(input logic [3:0] op, input string nm);
        logic [31:0] exp;
        MDUOp = op;
        #2;
        exp = (op == 4'd7) ? m_hi : (op == 4'd8) ? m_lo : 32'd0;
        check32(nm, Result, exp);
        MDUOp = 4'd0;
    endtask

    // Monitor: at each Busy fall, pop the expected commit and compare.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (Busy) mon_len++;
            else if (mon_prev) begin
                if (sb_q.size() == 0) begin
                    errors++; checks++;
                    $display("FAIL scoreboard: Busy window of %0d with no expected op", mon_len);
                end else begin
                    e = sb_q.pop_front();
                    check32({e.name, "_HI"}, HI, e.hi);
                    check32({e.name, "_LO"}, LO, e.lo);
                    check32({e.name, "_busy_len"}, 32'(mon_len), 32'(e.len));
                end
                mon_len = 0;
            end
            mon_prev = Busy;
        end
    end

    initial begin
        exp_t e;
        logic [3:0]  op;
        logic [31:0] ra, rb;
        int          sel;
        reset = 1'b0; Start = 1'b0; MDUOp = 4'd0; A = '0; B = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check32("rst_busy", 32'(Busy), 32'd0);
        check32("rst_HI", HI, 32'd0);
        check32("rst_LO", LO, 32'd0);
        read_result(4'd7, "rst_mfhi");

        // Directed test-plan cases.
        issue_arith(4'd1, 32'hFFFF_FFFD, 32'd5, "mult");   wait_idle();
        issue_arith(4'd2, 32'hFFFF_FFFD, 32'd5, "multu");  wait_idle();
        issue_arith(4'd3, 32'hFFFF_FFF9, 32'd2, "div");    wait_idle();
        issue_arith(4'd4, 32'd7, 32'd2, "divu");           wait_idle();
        issue_arith(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf"); wait_idle();
        mt(4'd5, 32'h11);
        mt(4'd6, 32'h22);
        issue_arith(4'd3, 32'd1234, 32'd0, "div0");        wait_idle();
        read_result(4'd7, "mfhi_after_div0");
        read_result(4'd8, "mflo_after_div0");
        read_result(4'd12, "result_code12");

        // MTHI during Busy cycle 3 is dropped.
        issue_arith(4'd1, 32'd1000, 32'd3000, "mult_ign");
        repeat (2) @(posedge clk);
        #1 drive(4'd5, 32'hDEAD, 32'd0);
        wait_idle();
        check32("ign_mthi_HI", HI, m_hi);

        // Reset in Busy cycle 4 of a DIV: commit discarded, HI/LO cleared.
        e.hi = 0; e.lo = 0; e.len = 4; e.name = "div_rst";
        sb_q.push_back(e);
        drive(4'd3, 32'd100, 32'd7);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        m_hi = 0; m_lo = 0;
        repeat (8) @(negedge clk);
        check32("post_rst_HI", HI, 32'd0);
        check32("post_rst_LO", LO, 32'd0);
        check32("post_rst_busy", 32'(Busy), 32'd0);

        // Back-to-back: second Start in the first Busy=0 cycle.
        issue_arith(4'd1, 32'd12345, 32'd6789, "b2b_1");
        wait_idle();
        issue_arith(4'd2, 32'hFFFF_0000, 32'h0001_FFFF, "b2b_2");
        wait_idle();

        // Randomized mix.
        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 9);
            ra  = $urandom();
            rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom();
            if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(0, 31);
            if (sel < 4) begin
                op = 4'(sel + 1);
                issue_arith(op, ra, rb, $sformatf("rnd%0d_op%0d", i, op));
                wait_idle();
            end else if (sel == 4) mt(4'd5, ra);
            else if (sel == 5) mt(4'd6, ra);
            else if (sel == 6) read_result(4'd7, $sformatf("rnd%0d_mfhi", i));
            else if (sel == 7) read_result(4'd8, $sformatf("rnd%0d_mflo", i));
            else read_result(4'($urandom_range(9, 15)), $sformatf("rnd%0d_none", i));
        end

        repeat (2) @(negedge clk);
        check32("sb_empty", 32'(sb_q.size()), 32'd0);
        check32("final_HI", HI, m_hi);
        check32("final_LO", LO, m_lo);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mdu.md
# mdu

Multiply/divide unit for the EX stage of the five-stage MIPS pipeline. It executes mult/multu/div/divu as multi-cycle operations, holds the architectural HI/LO registers, and serves mthi/mtlo/mfhi/mflo. The mfhi/mflo result travels down the M/W pipeline into the register file write port. The Busy output drives the hazard unit's stall decision.

## Interface
Parameters:
- MULT_CYCLES, 5, Busy duration for mult/multu.
- DIV_CYCLES, 10, Busy duration for div/divu.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-low (0 = reset); sampled on posedge clk.
- Start  in  1  one-cycle pulse: issue the op on MDUOp this cycle.
- MDUOp  in  4  operation code; meaningful only when Start=1, except MFHI/MFLO.
- A  in  32  rs operand; also the mthi/mtlo data.
- B  in  32  rt operand.
- Busy  out  1  a mult/div operation is in flight.
- HI  out  32  architectural HI register.
- LO  out  32  architectural LO register.
- Result  out  32  combinational read: HI if MDUOp=MFHI, LO if MDUOp=MFLO, else 0.

## Operation
- MDUOp encodings: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO. Codes 9–15 behave as NONE.
- FSM states: IDLE, RUN. A down-counter of 4 bits holds the remaining cycles.
- IDLE with Start and an arithmetic op:
  - The 64-bit result is computed from A/B and latched into temp_hi/temp_lo.
  - Counter is loaded with the op latency; state goes to RUN.
- RUN:
  - Counter decrements each edge.
  - On the edge where the counter reaches 0, temp_hi/temp_lo are copied to HI/LO and state returns to IDLE.
- MULT: signed 32x32 to 64, HI = upper word. MULTU: unsigned.
- DIV/DIVU:
  - LO = quotient, HI = remainder.
  - Signed division truncates toward zero; the remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0.
- Divide by zero (B = 0): the op still occupies DIV_CYCLES of Busy, but HI/LO are left unchanged.
- MTHI/MTLO with Start in IDLE: HI (or LO) <= A at that edge; no Busy.
- Start during RUN (any op, including MTHI/MTLO): ignored. The hazard unit guarantees this never happens; the MDU drops it safely.
- Result always reflects the committed HI/LO, never temp values.
- Reset (reset=0 at an edge), including mid-operation: HI = 0, LO = 0, Busy = 0, state IDLE, counter 0; the pending result is discarded.

## Timing
- Busy = (state == RUN). It is registered; no combinational path from Start.
- Start at edge N with MULT gives Busy=1 for cycles N+1 … N+5. HI/LO hold the new values from edge N+5 onward, and Busy is 0 in that same cycle.
- The DIV path has the same timing with 10 cycles.
- A new Start is accepted in the first cycle where Busy=0, so operations can issue back to back.
- MTHI/MTLO take effect at the Start edge; Result/HI/LO show the new value in the next cycle.
- Result has a zero-cycle combinational path from MDUOp and HI/LO.

## Structure
- Package mdu_pkg holds:
  - MDUOp localparams (NONE..MFLO);
  - state encoding IDLE/RUN;
  - default latency constants shared with the hazard unit, which decodes "is MD instruction" from the same codes.
- No sub-module. The arithmetic is two behavioural expressions (signed and unsigned product, quotient, remainder) inside one always block, plus a result mux.

## Test plan
- MULT, A = 0xFFFFFFFD (−3), B = 5 → Busy high for exactly 5 cycles, then HI = 0xFFFFFFFF, LO = 0xFFFFFFF1. MULTU with the same operands → HI = 0x00000004, LO = 0xFFFFFFF1.
- DIV, A = 0xFFFFFFF9 (−7), B = 2 → after 10 Busy cycles, LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIVU, A = 7, B = 2 → LO = 3, HI = 1.
- Set HI = 0x11, LO = 0x22 via MTHI/MTLO, then DIV with B = 0 → 10 Busy cycles, then HI = 0x11 and LO = 0x22 unchanged. MFHI → Result = 0x11; MFLO → Result = 0x22.
- Start MULT, then pulse Start MTHI with A = 0xDEAD in the third Busy cycle → ignored; after the 5th cycle, HI/LO equal the product, not 0xDEAD.
- Start DIV, drive reset = 0 for one edge in Busy cycle 4 → Busy = 0, HI = LO = 0, and HI/LO stay 0 through the cycles where the division would have completed.
- Back-to-back MULT: issue the second Start in the first cycle Busy = 0 → second Busy window begins on the next cycle, and HI/LO reflect the second product 5 cycles later.
